// File: rtl/alsu_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of the ALSU.
// Issues one op per cycle, tracks it through the ALSU's fixed latency, and returns tagged results.
module alsu_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    input  logic [6:0] req0_ctrl,
    input  logic       req0_lock,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    input  logic [6:0] req1_ctrl,
    input  logic       req1_lock,
    output logic [2:0] alsu_opcode,
    output logic [2:0] alsu_A,
    output logic [2:0] alsu_B,
    output logic       alsu_cin,
    output logic       alsu_red_op_A,
    output logic       alsu_red_op_B,
    output logic       alsu_bypass_A,
    output logic       alsu_bypass_B,
    output logic       alsu_direction,
    output logic       alsu_serial_in,
    input  logic [5:0] alsu_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [5:0] rsp_data,
    output logic       rsp_err
);

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    localparam logic [8:0] LockMax = 9'(LOCK_MAX);

    lock_state_t r_lock_state;
    logic        r_owner;
    logic        r_ptr;
    logic [7:0]  r_lock_cnt;

    logic [2:0]  r_opcode;
    logic [2:0]  r_a;
    logic [2:0]  r_b;
    logic [6:0]  r_ctrl;

    logic [2:0]  r_tag_v;
    logic [2:0]  r_tag_id;
    logic [2:0]  r_tag_err;

    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [5:0]  r_rsp_data;
    logic        r_rsp_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic        w_id;
    logic        w_illegal;
    logic        w_owner_valid;
    logic        w_sel_lock;
    logic [2:0]  w_op;
    logic [2:0]  w_a;
    logic [2:0]  w_b;
    logic [6:0]  w_ctrl;
    logic [8:0]  w_cnt_next;

    // Handshake: readyN is a grant that already implies validN; a request is
    // accepted on the rising edge where validN & readyN. At most one grant per cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_lock_state == LOCK_HELD) begin
            if (r_owner) w_gnt1 = req1_valid;
            else         w_gnt0 = req0_valid;
        end else if (req0_valid && req1_valid) begin
            if (r_ptr) w_gnt0 = 1'b1;
            else       w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end
    end

    assign req0_ready    = w_gnt0 & reset;
    assign req1_ready    = w_gnt1 & reset;
    assign w_acc         = w_gnt0 | w_gnt1;
    assign w_id          = w_gnt1;
    assign w_op          = w_id ? req1_op   : req0_op;
    assign w_a           = w_id ? req1_a    : req0_a;
    assign w_b           = w_id ? req1_b    : req0_b;
    assign w_ctrl        = w_id ? req1_ctrl : req0_ctrl;
    assign w_sel_lock    = w_id ? req1_lock : req0_lock;
    assign w_illegal     = w_op[2] & w_op[1];
    assign w_owner_valid = r_owner ? req1_valid : req0_valid;
    assign w_cnt_next    = {1'b0, r_lock_cnt} + 9'd1;

    // Lock FSM; the pointer always ends on the last owner so the other side wins next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_state <= LOCK_IDLE;
            r_owner      <= 1'b0;
            r_lock_cnt   <= 8'd0;
            r_ptr        <= 1'b1;
        end else if (w_acc) begin
            r_ptr   <= w_id;
            r_owner <= w_id;
            if (w_sel_lock && (w_cnt_next < LockMax)) begin
                r_lock_state <= LOCK_HELD;
                r_lock_cnt   <= w_cnt_next[7:0];
            end else begin
                r_lock_state <= LOCK_IDLE;
                r_lock_cnt   <= 8'd0;
            end
        end else if ((r_lock_state == LOCK_HELD) && !w_owner_valid) begin
            r_lock_state <= LOCK_IDLE;
            r_lock_cnt   <= 8'd0;
            r_ptr        <= r_owner;
        end
    end

    // Illegal opcodes and idle cycles both issue a NOP, which also breaks any shift chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode <= 3'd0;
            r_a      <= 3'd0;
            r_b      <= 3'd0;
            r_ctrl   <= 7'd0;
        end else if (w_acc && !w_illegal) begin
            r_opcode <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_ctrl   <= w_ctrl;
        end else begin
            r_opcode <= 3'd0;
            r_a      <= 3'd0;
            r_b      <= 3'd0;
            r_ctrl   <= 7'd0;
        end
    end

    assign alsu_opcode    = r_opcode;
    assign alsu_A         = r_a;
    assign alsu_B         = r_b;
    assign alsu_cin       = r_ctrl[6];
    assign alsu_red_op_A  = r_ctrl[5];
    assign alsu_red_op_B  = r_ctrl[4];
    assign alsu_bypass_A  = r_ctrl[3];
    assign alsu_bypass_B  = r_ctrl[2];
    assign alsu_direction = r_ctrl[1];
    assign alsu_serial_in = r_ctrl[0];

    // Tag stage 2 lines up with the cycle in which alsu_out holds that op's result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_v     <= 3'd0;
            r_tag_id    <= 3'd0;
            r_tag_err   <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 6'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_tag_v     <= {r_tag_v[1:0],   w_acc};
            r_tag_id    <= {r_tag_id[1:0],  w_acc & w_id};
            r_tag_err   <= {r_tag_err[1:0], w_acc & w_illegal};
            r_rsp_valid <= r_tag_v[2];
            r_rsp_id    <= r_tag_v[2] & r_tag_id[2];
            r_rsp_err   <= r_tag_v[2] & r_tag_err[2];
            r_rsp_data  <= (r_tag_v[2] && !r_tag_err[2]) ? alsu_out : 6'd0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/alsu_arbiter.md
# alsu_arbiter

Two-port request arbiter and sequencer placed in front of the ALSU. It accepts operation requests from two independent requesters and grants them round-robin. It drives the ALSU input bus one operation per cycle and tracks each operation through the ALSU's fixed latency. It returns every result tagged with the requester ID. It also keeps chained shift/rotate sequences atomic, and rejects illegal opcodes locally without disturbing the sequencing.

## Interface
Parameters:
- LOCK_MAX, 8, maximum consecutive locked grants to one requester before the lock is force-released (range 1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  grant; a request is accepted on an edge where valid & ready.
- req0_op / req1_op  in  3  ALSU opcode.
- req0_a, req0_b / req1_a, req1_b  in  3 each  operands.
- req0_ctrl / req1_ctrl  in  7  {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}.
- req0_lock / req1_lock  in  1  keep the grant for the next operation (chained shift/rotate).
- alsu_opcode  out  3  to ALSU; registered.
- alsu_A, alsu_B  out  3 each  to ALSU; registered.
- alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in  out  1 each  to ALSU; registered.
- alsu_out  in  6  ALSU result.
- rsp_valid  out  1  one-cycle result strobe; no backpressure.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  6  result (0 when rsp_err=1).
- rsp_err  out  1  operation rejected as illegal opcode.

## Operation
- Grant is combinational from the valids, the lock state and the round-robin pointer. At most one ready is high per cycle.
- Round-robin: the pointer records the last granted requester. When both requesters are valid and no lock is active, the other requester wins. The pointer resets to 1, so req0 wins first.
- Lock: accepting a request with lockN=1 sets lock owner = N and increments lock_cnt. While the lock is active, only the owner can be granted; the other requester's ready is forced to 0.
- The lock is released when any of the following occurs:
  - the owner is accepted with lockN=0;
  - the owner's valid is low in any cycle while the lock is active;
  - lock_cnt reaches LOCK_MAX, in which case the request accepted with that count is the last under lock.
- On release, lock_cnt is cleared and the pointer points to the owner, so the other requester is favoured next.
- Issue, on the accept edge:
  - a legal opcode (0..5) drives all alsu_* outputs from the granted fields;
  - an illegal opcode (6, 7) is accepted but drives a NOP instead;
  - when nothing is accepted, a NOP is driven.
- NOP = all alsu_* outputs 0.
- Chained shift/rotate state in the ALSU survives only across back-to-back accepted locked ops. Any NOP cycle breaks the chain; this is intended behaviour.
- Tag pipeline: 3 stages of {valid, id, err}, shifted every cycle and loaded on accept. A NOP cycle loads valid=0.

## Timing
- Accept at edge E0.
- alsu_* outputs change at E0.
- The ALSU registers its inputs at E1 and updates alsu_out at E2.
- rsp_valid/rsp_id/rsp_err/rsp_data are registered at E3, with rsp_data sampled from alsu_out. rsp_valid is high for the cycle after E3.
- Fixed latency: 3 cycles. Throughput: 1 op per cycle. Responses return in issue order.
- rsp_err=1 forces rsp_data=0 regardless of alsu_out.
- Reset asserted, at any time:
  - all outputs go to 0 immediately: ready, alsu_*, rsp_*;
  - the tag pipeline clears; in-flight ops produce no response;
  - lock and lock_cnt clear; the pointer is set to 1.
- Reset deassertion: the first grant is possible on the first edge after deassertion.
- Simultaneous event: when the lock releases and the other requester is valid on the same edge, the other requester is granted in the next cycle, not the same cycle.

## Test plan
- Single op: req0 valid, op=3, A=3, B=2, cin=1, others 0 → accepted at E0; alsu_opcode=3 after E0; rsp_valid at E3 with rsp_id=0, rsp_data=6, rsp_err=0.
- Contention: both valid every cycle out of reset, lock=0 → grants alternate 0,1,0,1; responses arrive in the same order, 3 cycles after each accept.
- Illegal opcode: req1 op=7, A=5 → alsu_* all 0 in the issue cycle; at E3 rsp_id=1, rsp_err=1, rsp_data=0. The following legal op is unaffected.
- Lock chain: req0 issues 4 ops with op=4, direction=1, lock=1,1,1,0, while req1 is held valid → req1_ready stays 0 for 4 cycles; req1 is granted in the cycle after req0's last accept.
- Forced release: LOCK_MAX=2; req0 lock=1 continuously and req1 valid → req0 is granted 2 times, then req1 is granted once, then req0 again.
- Reset mid-flight: accept 3 ops back to back, then assert reset 1 cycle after the last accept → no rsp_valid ever; all outputs are 0 during reset; after release, req0 is granted first.
